// File: rtl/dt_integrator.sv
// dt_integrator: rebuilds an absolute temperature from scaled dT samples, periodically re-anchored
module dt_integrator #(
  parameter int RESYNC_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init,
  input  logic signed [7:0] T_anchor,
  input  logic              anchor_valid,
  input  logic signed [7:0] dT_in,
  input  logic              dT_valid,
  input  logic [7:0]        k_dt,
  output logic signed [7:0] T_hat,
  output logic              t_valid,
  input  logic              t_ready,
  output logic              resync_req,
  output logic              sat_flag
);
  localparam int CW = $clog2(RESYNC_MAX + 1);
  typedef enum logic {IDLE, TRACK} state_t;
  state_t state_q, state_d;
  logic signed [7:0] acc_q, acc_d, t_hat_q, t_hat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic t_valid_q, t_valid_d, pending_q, pending_d, resync_q, resync_d, sat_q, sat_d;
  logic [2:0] k;
  logic signed [16:0] sum;
  logic integ, upd, clamped;
  always_comb begin
    k = (k_dt > 8'd7) ? 3'd7 : k_dt[2:0];
    sum = $signed({{9{acc_q[7]}}, acc_q}) + ($signed({{9{dT_in[7]}}, dT_in}) <<< k);
    clamped = (sum > 17'sd127) || (sum < -17'sd128);
    integ = (state_q == TRACK) && dT_valid && !anchor_valid && !init;
    upd = anchor_valid || integ;
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    resync_d = resync_q;
    sat_d = sat_q;
    t_hat_d = t_hat_q;
    t_valid_d = t_valid_q;
    pending_d = pending_q;
    if (anchor_valid) begin
      state_d = TRACK;
      acc_d = T_anchor;
      cnt_d = '0;
      resync_d = 1'b0;
      sat_d = 1'b0;
    end else if (integ) begin
      acc_d = clamped ? (sum[16] ? 8'h80 : 8'h7f) : sum[7:0];
      sat_d = sat_q || clamped;
      cnt_d = (cnt_q == CW'(RESYNC_MAX)) ? cnt_q : cnt_q + CW'(1);
      resync_d = resync_q || (cnt_d == CW'(RESYNC_MAX));
    end
    // a blocked slot keeps T_hat frozen; the newest acc goes out once it frees up
    if (!t_valid_q || t_ready) begin
      t_valid_d = pending_q || upd;
      t_hat_d = (pending_q || upd) ? acc_d : t_hat_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q || upd;
    end
    if (init) begin
      state_d = IDLE;
      acc_d = acc_q;
      sat_d = sat_q;
      t_hat_d = t_hat_q;
      t_valid_d = 1'b0;
      pending_d = 1'b0;
      cnt_d = '0;
      resync_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      t_hat_q <= '0;
      t_valid_q <= 1'b0;
      pending_q <= 1'b0;
      cnt_q <= '0;
      resync_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      t_hat_q <= t_hat_d;
      t_valid_q <= t_valid_d;
      pending_q <= pending_d;
      cnt_q <= cnt_d;
      resync_q <= resync_d;
      sat_q <= sat_d;
    end
  end
  assign T_hat = t_hat_q;
  assign t_valid = t_valid_q;
  assign resync_req = resync_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_dt_integrator.sv
// tb_dt_integrator: directed scenarios plus random traffic against an arithmetic reference model
module tb_dt_integrator;
  localparam int RMAX = 4;
  logic clk = 0, rst_n = 0, init = 0, anchor_valid = 0, dT_valid = 0, t_ready = 0;
  logic signed [7:0] T_anchor = 0, dT_in = 0;
  logic [7:0] k_dt = 0;
  logic signed [7:0] T_hat;
  logic t_valid, resync_req, sat_flag;
  int checks = 0, errors = 0;
  // reference model state
  int m_acc, m_th, m_cnt;
  bit m_trk, m_tv, m_pend, m_rs, m_sat;

  dt_integrator #(.RESYNC_MAX(RMAX)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .T_anchor(T_anchor), .anchor_valid(anchor_valid),
    .dT_in(dT_in), .dT_valid(dT_valid), .k_dt(k_dt), .T_hat(T_hat), .t_valid(t_valid),
    .t_ready(t_ready), .resync_req(resync_req), .sat_flag(sat_flag));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int a, s, sc, c;
    bit up, st, rs;
    if (!rst_n) begin
      m_trk <= 0; m_acc <= 0; m_th <= 0; m_tv <= 0; m_pend <= 0; m_cnt <= 0; m_rs <= 0; m_sat <= 0;
    end else if (init) begin
      m_trk <= 0; m_tv <= 0; m_pend <= 0; m_cnt <= 0; m_rs <= 0;
    end else begin
      a = m_acc; up = 0; st = m_sat; c = m_cnt; rs = m_rs;
      sc = (k_dt > 7) ? 128 : (1 << k_dt);
      if (anchor_valid) begin
        a = T_anchor; up = 1; st = 0; c = 0; rs = 0; m_trk <= 1;
      end else if (m_trk && dT_valid) begin
        s = m_acc + int'(dT_in) * sc;
        a = (s > 127) ? 127 : (s < -128) ? -128 : s;
        if (a != s) st = 1;
        if (c < RMAX) c++;
        if (c == RMAX) rs = 1;
        up = 1;
      end
      m_acc <= a; m_sat <= st; m_cnt <= c; m_rs <= rs;
      if (!m_tv || t_ready) begin
        m_tv <= m_pend || up;
        if (m_pend || up) m_th <= a;
        m_pend <= 0;
      end else m_pend <= m_pend || up;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("model T_hat", T_hat, m_th);
    chk("model t_valid", t_valid, m_tv);
    chk("model resync_req", resync_req, m_rs);
    chk("model sat_flag", sat_flag, m_sat);
  end

  task automatic cyc(input bit i, input bit a, input int ta, input bit dv, input int d,
                     input int k, input bit r);
    init = i; anchor_valid = a; T_anchor = 8'(ta); dT_valid = dv; dT_in = 8'(d);
    k_dt = 8'(k); t_ready = r;
    @(posedge clk); @(negedge clk); #2;
  endtask

  initial begin
    #12 rst_n = 1;
    @(negedge clk); #2;
    // T1 reset mid-stream
    cyc(0, 1, 50, 0, 0, 0, 1);
    chk("t1 pre T_hat", T_hat, 50);
    rst_n = 0; #1;
    chk("t1 rst T_hat", T_hat, 0);
    chk("t1 rst t_valid", t_valid, 0);
    chk("t1 rst resync", resync_req, 0);
    chk("t1 rst sat", sat_flag, 0);
    #1 rst_n = 1;
    cyc(0, 0, 0, 1, 5, 0, 1);
    cyc(0, 0, 0, 1, 5, 0, 1);
    chk("t1 idle t_valid", t_valid, 0);
    // T2 track
    cyc(0, 1, 20, 0, 0, 3, 1); chk("t2 anchor", T_hat, 20);
    cyc(0, 0, 0, 1, 1, 3, 1);  chk("t2 dT1", T_hat, 28);
    cyc(0, 0, 0, 1, 1, 3, 1);  chk("t2 dT2", T_hat, 36);
    cyc(0, 0, 0, 1, -2, 3, 1); chk("t2 dT3", T_hat, 20);
    // T3 clamp
    cyc(0, 1, 120, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 20, 0, 1);   chk("t3 hi clamp", T_hat, 127); chk("t3 sat", sat_flag, 1);
    cyc(0, 0, 0, 1, -128, 0, 1); chk("t3 -128 a", T_hat, -1);
    cyc(0, 0, 0, 1, -128, 0, 1); chk("t3 lo clamp", T_hat, -128);
    cyc(0, 1, 0, 0, 0, 0, 1);    chk("t3 anchor clr sat", sat_flag, 0);
    // T4 backpressure
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0); chk("t4 anchor", T_hat, 0);
    cyc(0, 0, 0, 1, 2, 0, 0); chk("t4 held", T_hat, 0);
    cyc(0, 0, 0, 1, 3, 0, 0); chk("t4 held2", T_hat, 0); chk("t4 tv", t_valid, 1);
    cyc(0, 0, 0, 0, 0, 0, 1); chk("t4 release", T_hat, 5);
    // T5 resync
    cyc(0, 1, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3; n++) cyc(0, 0, 0, 1, 1, 0, 1);
    chk("t5 before", resync_req, 0);
    cyc(0, 0, 0, 1, 1, 0, 1); chk("t5 4th", resync_req, 1);
    cyc(0, 0, 0, 1, 1, 0, 1); chk("t5 5th", resync_req, 1); chk("t5 still integ", T_hat, 5);
    cyc(0, 1, 9, 0, 0, 0, 1); chk("t5 anchor drop", resync_req, 0);
    // T6 priority
    cyc(0, 1, 10, 0, 0, 0, 1);
    cyc(1, 1, 33, 1, 4, 0, 1); chk("t6 init wins", t_valid, 0);
    cyc(0, 0, 0, 1, 4, 0, 1);  chk("t6 idle ignores dT", t_valid, 0);
    cyc(0, 1, -7, 1, 4, 0, 1); chk("t6 anchor over dT", T_hat, -7);
    cyc(0, 0, 0, 1, 4, 0, 1);  chk("t6 next dT", T_hat, -3);
    // random traffic
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)) - 128,
          $urandom_range(0, 1) == 1, int'($urandom_range(0, 255)) - 128,
          ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
